// File: rtl/lfsr_seq_checker_pkg.sv
// lfsr_seq_checker_pkg: shared state encodings and default taps for the
// LFSR generator / checker pair (REG_SIZE=8 default feedback mask).
package lfsr_seq_checker_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int         DEFAULT_REG_SIZE = 8;
  localparam logic [7:0] DEFAULT_TAPS     = 8'hB8;

endpackage

// File: rtl/lfsr_next_bit.sv
// lfsr_next_bit: combinational LFSR prediction, ^(state & TAPS).
// Ports: state (REG_SIZE history/register), next_bit (predicted bit).
module lfsr_next_bit
  import lfsr_seq_checker_pkg::*;
#(
  parameter int                  REG_SIZE = DEFAULT_REG_SIZE,
  parameter logic [REG_SIZE-1:0] TAPS     = DEFAULT_TAPS
) (
  input  logic [REG_SIZE-1:0] state,
  output logic                next_bit
);

  assign next_bit = ^(state & TAPS);

endmodule

// File: rtl/lfsr_seq_checker.sv
// lfsr_seq_checker: self-synchronising serial LFSR checker with lock and
// saturating error count. Ports: clk, reset (async high), bit_in,
// bit_valid, clear_err -> locked, err_pulse, err_count, state.
// Option: LFSR_CHK_ZERO_GUARD_EN drops an all-zero history back to FILL.
module lfsr_seq_checker
  import lfsr_seq_checker_pkg::*;
#(
  parameter int                  REG_SIZE    = DEFAULT_REG_SIZE,
  parameter logic [REG_SIZE-1:0] TAPS        = DEFAULT_TAPS,
  parameter int                  LOCK_COUNT  = 16,
  parameter int                  LOSS_THRESH = 4,
  parameter int                  ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clear_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state
);

  localparam int FW = $clog2(REG_SIZE) + 1;
  localparam int MW = $clog2(LOCK_COUNT) + 1;
  localparam int BW = $clog2(LOSS_THRESH) + 1;

  state_e              state_q, state_d;
  logic [REG_SIZE-1:0] hist_q, hist_d;
  logic [FW-1:0]       fill_q, fill_d;
  logic [MW-1:0]       match_q, match_d;
  logic [BW-1:0]       bad_q, bad_d;
  logic [ERR_W-1:0]    cnt_q, cnt_d;
  logic                locked_q, locked_d;
  logic                pulse_q;
  logic                err_now;
  logic                expected;
  logic                match;
  logic                zero_hit;

  lfsr_next_bit #(
    .REG_SIZE (REG_SIZE),
    .TAPS     (TAPS)
  ) u_pred (
    .state    (hist_q),
    .next_bit (expected)
  );

  assign match = (bit_in == expected);

`ifdef LFSR_CHK_ZERO_GUARD_EN
  assign zero_hit = (hist_q == '0);
`else
  assign zero_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = match_q;
    bad_d   = bad_q;
    err_now = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (bit_valid) begin
          hist_d = {bit_in, hist_q[REG_SIZE-1:1]};
          if (fill_q == FW'(REG_SIZE - 1)) begin
            state_d = ST_SYNC;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
      end
      ST_SYNC: begin
        if (bit_valid) begin
          hist_d = {bit_in, hist_q[REG_SIZE-1:1]};
          if (zero_hit) begin
            state_d = ST_FILL;
            fill_d  = '0;
            match_d = '0;
            bad_d   = '0;
          end else if (!match) begin
            match_d = '0;
          end else if (match_q == MW'(LOCK_COUNT - 1)) begin
            state_d = ST_LOCKED;
            match_d = '0;
            bad_d   = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (bit_valid) begin
          if (zero_hit) begin
            hist_d  = {bit_in, hist_q[REG_SIZE-1:1]};
            state_d = ST_FILL;
            fill_d  = '0;
            match_d = '0;
            bad_d   = '0;
          end else begin
            // Free-run on the prediction so one bad bit is not re-fed.
            hist_d = {expected, hist_q[REG_SIZE-1:1]};
            if (match) begin
              bad_d = '0;
            end else begin
              err_now = 1'b1;
              if (bad_q == BW'(LOSS_THRESH - 1)) begin
                state_d = ST_FILL;
                fill_d  = '0;
                bad_d   = '0;
              end else begin
                bad_d = bad_q + 1'b1;
              end
            end
          end
        end
      end
      default: begin
        state_d = ST_FILL;
        fill_d  = '0;
        match_d = '0;
        bad_d   = '0;
      end
    endcase
    locked_d = (state_d == ST_LOCKED);
    cnt_d = cnt_q;
    if (clear_err)
      cnt_d = err_now ? ERR_W'(1) : '0;
    else if (err_now && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FILL;
      hist_q   <= '0;
      fill_q   <= '0;
      match_q  <= '0;
      bad_q    <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hist_q   <= hist_d;
      fill_q   <= fill_d;
      match_q  <= match_d;
      bad_q    <= bad_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      pulse_q  <= err_now;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_count = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// tb_lfsr_seq_checker: scoreboard bench for lfsr_seq_checker, driving a
// local 8-bit LFSR (taps B8) stream into a 16-bit and a 4-bit counter DUT.
module tb_lfsr_seq_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        clear_err = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [1:0]  state;
  logic        locked4, err_pulse4;
  logic [3:0]  err_count4;
  logic [1:0]  state4;

  int errors = 0;
  int checks = 0;
  logic [7:0] g;

`ifdef LFSR_CHK_ZERO_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic       lk;
    logic       pl;
    logic [15:0] cnt;
    logic [1:0] st;
  } exp_t;

  exp_t exp_q[$];

  lfsr_seq_checker dut (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear_err (clear_err),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .state     (state)
  );

  lfsr_seq_checker #(.ERR_W(4)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .clear_err (clear_err),
    .locked    (locked4),
    .err_pulse (err_pulse4),
    .err_count (err_count4),
    .state     (state4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, act, exp, $time);
    end
  endtask

  task automatic nxt(output logic b);
    b = ^(g & 8'hB8);
    g = {b, g[7:1]};
  endtask

  function automatic logic [1:0] st_of(input int n);
    if (n < 8) return 2'd0;
    if (n < 24) return 2'd1;
    return 2'd2;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, 32'(state), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_pulse"}, 32'(err_pulse), 0);
    chk({tag, "_count"}, 32'(err_count), 0);
    chk({tag, "_count4"}, 32'(err_count4), 0);
  endtask

  task automatic step(input logic b, input logic v, input logic clr,
                      input logic lk, input logic pl, input int cnt,
                      input logic [1:0] st);
    exp_t e;
    int   c4;
    e.lk  = lk;
    e.pl  = pl;
    e.cnt = 16'(cnt);
    e.st  = st;
    exp_q.push_back(e);
    bit_in    = b;
    bit_valid = v;
    clear_err = clr;
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    c4 = (e.cnt > 15) ? 15 : int'(e.cnt);
    chk("locked", 32'(locked), 32'(e.lk));
    chk("err_pulse", 32'(err_pulse), 32'(e.pl));
    chk("err_count", 32'(err_count), 32'(e.cnt));
    chk("state", 32'(state), 32'(e.st));
    chk("err_count_w4", 32'(err_count4), 32'(c4));
  endtask

  initial begin
    logic b;
    logic v;
    int   vc;

    // reset values
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    reset = 1'b0;

    // clean stream from seed 01: lock after the 24th bit
    g = 8'h01;
    for (int n = 1; n <= 1000; n++) begin
      nxt(b);
      step(b, 1'b1, 1'b0, n >= 24, 1'b0, 0, st_of(n));
    end

    // single inverted bit
    nxt(b);
    step(~b, 1'b1, 1'b0, 1'b1, 1'b1, 1, 2'd2);
    for (int n = 0; n < 50; n++) begin
      nxt(b);
      step(b, 1'b1, 1'b0, 1'b1, 1'b0, 1, 2'd2);
    end

    // clear, then four consecutive errors drop lock
    nxt(b);
    step(b, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2'd2);
    for (int k = 1; k <= 4; k++) begin
      nxt(b);
      step(~b, 1'b1, 1'b0, k < 4, 1'b1, k, (k < 4) ? 2'd2 : 2'd0);
    end
    for (int k = 1; k <= 34; k++) begin
      nxt(b);
      step(b, 1'b1, 1'b0, k >= 24, 1'b0, 4, st_of(k));
    end

    // asynchronous reset while locked
    #2;
    reset = 1'b1;
    #1;
    chk_reset("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // random bit_valid: lock at the 24th valid bit
    g  = 8'h01;
    vc = 0;
    for (int i = 0; i < 2000 && vc < 60; i++) begin
      v = 1'($urandom_range(0, 1));
      if (v) begin
        nxt(b);
        vc++;
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      step(b, v, 1'b0, vc >= 24, 1'b0, 0, st_of(vc));
    end
    chk("valid_bits", 32'(vc), 60);

    // clear coincident with an error, then saturation on ERR_W=4
    nxt(b);
    step(~b, 1'b1, 1'b1, 1'b1, 1'b1, 1, 2'd2);
    nxt(b);
    step(b, 1'b1, 1'b1, 1'b1, 1'b0, 0, 2'd2);
    for (int i = 1; i <= 20; i++) begin
      nxt(b);
      step(~b, 1'b1, 1'b0, 1'b1, 1'b1, i, 2'd2);
      nxt(b);
      step(b, 1'b1, 1'b0, 1'b1, 1'b0, i, 2'd2);
    end

    // all-zero stream
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (GUARD)
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0,
             (n % 9 == 8) ? 2'd1 : 2'd0);
      else
        step(1'b0, 1'b1, 1'b0, n >= 24, 1'b0, 0, st_of(n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
